// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame constants and parity helper.
// Used by both the word transmitter and the receive side.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data_byte);
    return ^data_byte;
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Valid/ready word handshake between the filter output and the UART word transmitter.
interface uart_word_tx_if;

  logic signed [15:0] data_in;
  logic               data_valid;
  logic               data_ready;

  modport master (output data_in, output data_valid, input  data_ready);
  modport slave  (input  data_in, input  data_valid, output data_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses o_tick on the last count.
// i_restart holds the count at zero so a new bit period starts cleanly.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments and an async reset so every flop
  // updates from pre-edge values and reset takes effect without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_restart || (r_count == CNT_LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tick = !i_restart && (r_count == CNT_LAST);

endmodule

// File: rtl/uart_word_tx.sv
// Sends one signed 16-bit sample as two UART frames (low byte first) with a valid/ready input.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits of each byte.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  uart_word_tx_if.slave  word_if,
  output logic           tx_data,
  output logic           busy
);

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       STOP_LAST = (STOP_BITS == 2);

  tx_state_t   r_state;
  tx_state_t   w_next_state;
  logic [15:0] r_shift;
  logic        r_byte_idx;
  logic [2:0]  r_bit_idx;
  logic        r_stop_idx;
  logic        w_tick;
  logic        w_accept;
  logic        w_restart;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  assign w_accept  = word_if.data_valid && (r_state == IDLE);
  assign w_restart = (r_state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk       (clk),
    .rst_n     (reset),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next_state = START;
      START: if (w_tick)   w_next_state = DATA;
      DATA: begin
        if (w_tick && (r_bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          w_next_state = PARITY;
`else
          w_next_state = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_tick) w_next_state = STOP;
`endif
      STOP: begin
        if (w_tick && (r_stop_idx == STOP_LAST)) begin
          w_next_state = r_byte_idx ? IDLE : START;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: the word is latched once and shifted right, so byte 1 lands in r_shift[7:0]
  // after the eight data bits of byte 0 have gone out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift    <= '0;
      r_byte_idx <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift    <= word_if.data_in;
            r_byte_idx <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
          end
        end
`ifdef UART_TX_PARITY_EN
        START: r_parity <= even_parity(r_shift[UART_DATA_BITS-1:0]);
`endif
        DATA: begin
          if (w_tick) begin
            r_shift   <= {1'b0, r_shift[15:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_stop_idx == STOP_LAST) begin
              r_stop_idx <= 1'b0;
              r_byte_idx <= ~r_byte_idx;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_data            = UART_IDLE_LVL;
    busy               = (r_state != IDLE);
    word_if.data_ready = (r_state == IDLE);
    case (r_state)
      START:  tx_data = 1'b0;
      DATA:   tx_data = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_data = r_parity;
`endif
      default: tx_data = UART_IDLE_LVL;
    endcase
  end

endmodule
